cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Direct-mapped, write-through, no-write-allocate cache controller that sits between a pipeline memory port and main memory and drives an external single-port `cache_sram` data array (synchronous write, combinational read). It holds the tag and valid arrays internally, answers read hits in the request cycle, refills on read misses and forwards every store to memory. It also provides hit and miss performance counters.

## Interface
- `WIDTH`, 32, data word width. Must match the data array.
- `DEPTH`, 16, number of lines, one word per line, power of two. `IDX = $clog2(DEPTH)`, `TAG = 30 - IDX`.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `cpu_req` in 1: access request. The requester holds it and all `cpu_*` inputs stable until `cpu_ready`.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in 32: byte address. Bits [1:0] are ignored.
- `cpu_wdata` in WIDTH: store data.
- `cpu_rdata` out WIDTH: load data. Valid only while `cpu_ready`.
- `cpu_ready` out 1: completion pulse. The request is consumed at that rising edge.
- `sram_addr` out IDX: data array index.
- `sram_wdata` out WIDTH: data array write data.
- `sram_wea` out 1: data array write enable.
- `sram_rdata` in WIDTH: data array read data, combinational from `sram_addr`.
- `mem_req` out 1: memory request. Held high until `mem_ack`.
- `mem_we` out 1: memory write.
- `mem_addr` out 32: word-aligned byte address, `{addr[31:2],2'b00}`.
- `mem_wdata` out WIDTH: memory write data.
- `mem_rdata` in WIDTH: memory read data. Valid in the `mem_ack` cycle.
- `mem_ack` in 1: memory completion. Ignored unless `mem_req` is high.
- `hit_cnt` out 32: count of hits.
- `miss_cnt` out 32: count of misses.

## Operation
- Address split:
  - index = `addr[IDX+1:2]`
  - tag = `addr[31:IDX+2]`
  - hit = `valid[index] && tag_arr[index] == tag`
- States: IDLE, REFILL, WRITE, RESP.
- IDLE behaviour:
  - `sram_addr` = index of the live `cpu_addr`.
  - Load hit: `cpu_ready` = 1 and `cpu_rdata` = `sram_rdata` combinationally. Stay in IDLE. `hit_cnt`++.
  - Load miss: latch addr and the we flag. Go to REFILL. `miss_cnt`++.
  - Store, hit or miss: latch addr, wdata and the hit flag (`hit_q`). Go to WRITE. `hit_cnt`++ on a hit, `miss_cnt`++ on a miss.
- REFILL:
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr` from the latched address.
  - On `mem_ack`: `sram_wea`=1, `sram_wdata`=`mem_rdata`, `tag_arr[idx]`=tag, `valid[idx]`=1. Capture `mem_rdata` into `rdata_q`. Go to RESP.
- WRITE:
  - Drive `mem_req`=1, `mem_we`=1, `mem_wdata` = latched wdata.
  - On `mem_ack`: if `hit_q`, then `sram_wea`=1 and `sram_wdata` = latched wdata. Tags and valid bits are unchanged (no allocate). Go to RESP.
- RESP:
  - `cpu_ready`=1. `cpu_rdata` = `rdata_q` for loads; don't-care for stores.
  - Unconditionally go to IDLE. `cpu_*` inputs are not evaluated in RESP.
- Outside IDLE, `sram_addr` = latched index and the `cpu_*` inputs are ignored.
- Counters are free-running 32-bit and wrap at 2^32. They are incremented only at the IDLE decision edge.
- Reset (async, any state):
  - state → IDLE, all valid bits → 0.
  - `mem_req`, `mem_we`, `sram_wea`, `cpu_ready` → 0. `hit_cnt`, `miss_cnt`, `rdata_q` → 0.
  - Tag and data arrays are not cleared.
  - A `mem_ack` arriving after a mid-transaction reset is ignored, because `mem_req` is 0.
- Simultaneous events:
  - A `mem_ack` in the same cycle `mem_req` first rises is legal and completes the transaction.
  - A store to a line currently being refilled cannot occur, because the controller is blocking.

## Timing
- Load hit: 0-cycle latency. `cpu_ready` is asserted in the request cycle (T0).
- Load miss: request at T0. `mem_req` is high from T1. With `mem_ack` at Tk (k≥1), `cpu_ready` is high at Tk+1. The data array and tag are written at the Tk edge.
- Store: request at T0, `mem_req`/`mem_we` high from T1, `mem_ack` at Tk, `cpu_ready` at Tk+1. The data array is updated at the Tk edge only if the line hit at T0.
- `cpu_ready` is exactly one cycle per miss or store. After RESP, IDLE may accept a new request immediately.
- `mem_*` outputs are registered and stable while `mem_req` is high. `sram_wea` is high for exactly one cycle, and only in the `mem_ack` cycle.

## Test plan
- Reset, then load `0x40`. The memory returns `0xDEADBEEF` with ack 2 cycles after `mem_req` rises:
  - `mem_addr`=`0x40`, `mem_we`=0.
  - `cpu_ready` rises 1 cycle after ack with `0xDEADBEEF`.
  - `miss_cnt`=1.
- Repeat the load of `0x40`:
  - `cpu_ready` and `0xDEADBEEF` in the same cycle.
  - `mem_req` stays 0.
  - `hit_cnt`=1.
- Store `0x12345678` to `0x40`:
  - `mem_req`/`mem_we`=1 with `mem_wdata`=`0x12345678`.
  - On ack, `sram_wea` pulses.
  - A following load of `0x40` hits and returns `0x12345678`.
- Store to `0x80` (same index as `0x40` when DEPTH=16, different tag):
  - Memory write is issued and `sram_wea` stays 0.
  - A load of `0x40` still hits.
  - A load of `0x80` misses.
- Load miss to `0x100`, then assert `rst` while `mem_req`=1 and before ack:
  - `mem_req` → 0 immediately.
  - A late `mem_ack` causes no SRAM write.
  - A load of `0x40` now misses (valid bits cleared); counters read 0 after reset.
- Zero-wait memory (`mem_ack` high whenever `mem_req` is high): load miss completes with `cpu_ready` at T2. Back-to-back accesses to 16 distinct indices give `miss_cnt`=16; replaying all 16 gives `hit_cnt`=16.

Source files
------------

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-through, no-write-allocate cache controller.
// Sits between a blocking pipeline memory port and main memory. Tag and valid
// arrays live here; the data array is an external single-port SRAM with
// synchronous write and combinational read.
//
// Ports
//   clk_i, rst_i          clock, async active-high reset
//   cpu_req_i/we_i        request / store flag, held until cpu_ready_o
//   cpu_addr_i/wdata_i    byte address (bits [1:0] ignored) / store data
//   cpu_rdata_o/ready_o   load data / completion pulse
//   sram_addr_o/wdata_o   data array index / write data
//   sram_wea_o            data array write enable
//   sram_rdata_i          data array read data (combinational)
//   mem_req_o/we_o        memory request (held until mem_ack_i) / write
//   mem_addr_o/wdata_o    word-aligned memory address / write data
//   mem_rdata_i/ack_i     memory read data / completion
//   hit_cnt_o/miss_cnt_o  free-running performance counters
//
// state  | meaning
// IDLE   | evaluate live cpu request; load hits complete here
// REFILL | load miss, waiting on memory read
// WRITE  | store forwarded to memory, waiting on ack
// RESP   | one-cycle completion pulse for miss/store
module cache_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int IDX  = $clog2(DEPTH),
    localparam int TAG  = 30 - IDX
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cpu_req_i,
    input  logic             cpu_we_i,
    input  logic [31:0]      cpu_addr_i,
    input  logic [WIDTH-1:0] cpu_wdata_i,
    output logic [WIDTH-1:0] cpu_rdata_o,
    output logic             cpu_ready_o,
    output logic [IDX-1:0]   sram_addr_o,
    output logic [WIDTH-1:0] sram_wdata_o,
    output logic             sram_wea_o,
    input  logic [WIDTH-1:0] sram_rdata_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    input  logic [WIDTH-1:0] mem_rdata_i,
    input  logic             mem_ack_i,
    output logic [31:0]      hit_cnt_o,
    output logic [31:0]      miss_cnt_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REFILL = 2'd1;
    localparam logic [1:0] WRITE  = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [31:2]      addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             hit_q, hit_d;
    logic             we_q, we_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [31:0]      hit_cnt_q, hit_cnt_d;
    logic [31:0]      miss_cnt_q, miss_cnt_d;
    logic [TAG-1:0]   tag_q [DEPTH];

    logic [IDX-1:0]   cpu_idx;
    logic [TAG-1:0]   cpu_tag;
    logic [IDX-1:0]   lat_idx;
    logic             hit;
    logic             ack;
    logic             refill_done;
    logic             unused_addr_bits;

    assign cpu_idx = cpu_addr_i[IDX+1:2];
    assign cpu_tag = cpu_addr_i[31:IDX+2];
    assign lat_idx = addr_q[IDX+1:2];
    assign hit     = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

    // mem_ack_i only counts while a request is outstanding, so a stray ack
    // after a mid-transaction reset is harmless.
    assign ack         = mem_ack_i && mem_req_q;
    assign refill_done = (state_q == REFILL) && ack;

    assign unused_addr_bits = &{1'b0, cpu_addr_i[1:0]};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        hit_d      = hit_q;
        we_d       = we_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        valid_d    = valid_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
                    else     miss_cnt_d = miss_cnt_q + 32'd1;
                    if (cpu_we_i) begin
                        addr_d    = cpu_addr_i[31:2];
                        wdata_d   = cpu_wdata_i;
                        hit_d     = hit;
                        we_d      = 1'b1;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b1;
                        state_d   = WRITE;
                    end else if (!hit) begin
                        addr_d    = cpu_addr_i[31:2];
                        we_d      = 1'b0;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                        state_d   = REFILL;
                    end
                end
            end
            REFILL: begin
                if (ack) begin
                    rdata_d          = mem_rdata_i;
                    valid_d[lat_idx] = 1'b1;
                    mem_req_d        = 1'b0;
                    state_d          = RESP;
                end
            end
            WRITE: begin
                if (ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            hit_q      <= 1'b0;
            we_q       <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            valid_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            hit_q      <= hit_d;
            we_q       <= we_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            valid_q    <= valid_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Tag array is intentionally not reset; valid bits gate its use.
    always_ff @(posedge clk_i) begin
        if (refill_done) tag_q[lat_idx] <= addr_q[31:IDX+2];
    end

    always_comb begin
        sram_addr_o  = (state_q == IDLE) ? cpu_idx : lat_idx;
        sram_wea_o   = refill_done || ((state_q == WRITE) && ack && hit_q);
        sram_wdata_o = (state_q == REFILL) ? mem_rdata_i : wdata_q;
        cpu_ready_o  = (state_q == RESP) ||
                       ((state_q == IDLE) && cpu_req_i && !cpu_we_i && hit);
        if (state_q == RESP) cpu_rdata_o = we_q ? '0 : rdata_q;
        else                 cpu_rdata_o = sram_rdata_i;
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = {addr_q, 2'b00};
    assign mem_wdata_o = wdata_q;
    assign hit_cnt_o   = hit_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        cpu_req_i = 1'b0;
    logic        cpu_we_i = 1'b0;
    logic [31:0] cpu_addr_i = '0;
    logic [31:0] cpu_wdata_i = '0;
    logic [31:0] cpu_rdata_o;
    logic        cpu_ready_o;
    logic [3:0]  sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic        sram_wea_o;
    logic [31:0] sram_rdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;

    logic        zw = 1'b0;
    logic        ack_man = 1'b0;
    logic [31:0] rd_man = '0;
    logic [31:0] sram [16];
    int          sram_wr_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    cache_ctrl #(.WIDTH(32), .DEPTH(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_ready_o(cpu_ready_o),
        .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o), .sram_wea_o(sram_wea_o),
        .sram_rdata_i(sram_rdata_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    always_ff @(posedge clk_i) begin
        if (sram_wea_o) begin
            sram[sram_addr_o] <= sram_wdata_o;
            sram_wr_cnt <= sram_wr_cnt + 1;
        end
    end
    assign sram_rdata_i = sram[sram_addr_o];

    always_comb begin
        mem_ack_i   = zw ? mem_req_o : ack_man;
        mem_rdata_i = zw ? (mem_addr_o ^ 32'hA5A5_0000) : rd_man;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        cpu_req_i   = 1'b1;
        cpu_we_i    = we;
        cpu_addr_i  = addr;
        cpu_wdata_i = wd;
    endtask

    initial begin
        int wr0;
        logic [31:0] a;

        // reset
        rst_i = 1'b1;
        step(); step();
        rst_i = 1'b0;
        #1;
        chk("rst_hit_cnt", hit_cnt_o, 32'd0);
        chk("rst_miss_cnt", miss_cnt_o, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_cpu_ready", {31'd0, cpu_ready_o}, 32'd0);
        chk("rst_sram_wea", {31'd0, sram_wea_o}, 32'd0);

        // load miss 0x40, ack 2 cycles after mem_req rises
        step(); req(1'b0, 32'h40, '0); #1;
        chk("miss_ready_t0", {31'd0, cpu_ready_o}, 32'd0);
        chk("miss_sram_addr", {28'd0, sram_addr_o}, 32'd0);
        step(); #1;
        chk("miss_mem_req", {31'd0, mem_req_o}, 32'd1);
        chk("miss_mem_addr", mem_addr_o, 32'h40);
        chk("miss_mem_we", {31'd0, mem_we_o}, 32'd0);
        chk("miss_cnt_1", miss_cnt_o, 32'd1);
        chk("miss_wait_ready", {31'd0, cpu_ready_o}, 32'd0);
        step();
        step(); ack_man = 1'b1; rd_man = 32'hDEADBEEF; #1;
        chk("refill_wea", {31'd0, sram_wea_o}, 32'd1);
        chk("refill_ready_ack", {31'd0, cpu_ready_o}, 32'd0);
        step(); ack_man = 1'b0; #1;
        chk("refill_ready", {31'd0, cpu_ready_o}, 32'd1);
        chk("refill_rdata", cpu_rdata_o, 32'hDEADBEEF);
        chk("refill_mem_req_low", {31'd0, mem_req_o}, 32'd0);
        chk("refill_wea_once", {31'd0, sram_wea_o}, 32'd0);

        // load hit 0x40
        step(); req(1'b0, 32'h40, '0); #1;
        chk("hit_ready", {31'd0, cpu_ready_o}, 32'd1);
        chk("hit_rdata", cpu_rdata_o, 32'hDEADBEEF);
        step(); cpu_req_i = 1'b0; #1;
        chk("hit_no_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("hit_cnt_1", hit_cnt_o, 32'd1);

        // store hit 0x40, ack in the first mem_req cycle
        step(); req(1'b1, 32'h40, 32'h12345678);
        step(); ack_man = 1'b1; #1;
        chk("st_mem_req", {31'd0, mem_req_o}, 32'd1);
        chk("st_mem_we", {31'd0, mem_we_o}, 32'd1);
        chk("st_mem_wdata", mem_wdata_o, 32'h12345678);
        chk("st_mem_addr", mem_addr_o, 32'h40);
        chk("st_hit_cnt", hit_cnt_o, 32'd2);
        chk("st_hit_wea", {31'd0, sram_wea_o}, 32'd1);
        step(); ack_man = 1'b0; #1;
        chk("st_ready", {31'd0, cpu_ready_o}, 32'd1);
        step(); req(1'b0, 32'h40, '0); #1;
        chk("st_readback_ready", {31'd0, cpu_ready_o}, 32'd1);
        chk("st_readback_data", cpu_rdata_o, 32'h12345678);

        // store miss 0x80 (same index, different tag): no allocate
        step(); req(1'b1, 32'h80, 32'h0BADF00D);
        step(); ack_man = 1'b1; #1;
        chk("stm_mem_req", {31'd0, mem_req_o}, 32'd1);
        chk("stm_mem_addr", mem_addr_o, 32'h80);
        chk("stm_miss_cnt", miss_cnt_o, 32'd2);
        chk("stm_no_wea", {31'd0, sram_wea_o}, 32'd0);
        step(); ack_man = 1'b0; #1;
        chk("stm_ready", {31'd0, cpu_ready_o}, 32'd1);
        step(); req(1'b0, 32'h40, '0); #1;
        chk("stm_0x40_hit", {31'd0, cpu_ready_o}, 32'd1);
        chk("stm_0x40_data", cpu_rdata_o, 32'h12345678);
        step(); req(1'b0, 32'h80, '0); #1;
        chk("ld_0x80_miss", {31'd0, cpu_ready_o}, 32'd0);
        step(); ack_man = 1'b1; rd_man = 32'hCAFEF00D; #1;
        chk("ld_0x80_mem_addr", mem_addr_o, 32'h80);
        chk("ld_0x80_miss_cnt", miss_cnt_o, 32'd3);
        step(); ack_man = 1'b0; #1;
        chk("ld_0x80_data", cpu_rdata_o, 32'hCAFEF00D);

        // load miss 0x100 aborted by reset, late ack ignored
        step(); req(1'b0, 32'h100, '0);
        step(); #1;
        chk("abort_mem_req", {31'd0, mem_req_o}, 32'd1);
        rst_i = 1'b1; cpu_req_i = 1'b0; #1;
        chk("abort_mem_req_low", {31'd0, mem_req_o}, 32'd0);
        chk("abort_hit_cnt", hit_cnt_o, 32'd0);
        chk("abort_miss_cnt", miss_cnt_o, 32'd0);
        step(); rst_i = 1'b0;
        wr0 = sram_wr_cnt;
        ack_man = 1'b1; rd_man = 32'h55AA55AA; #1;
        chk("late_ack_wea", {31'd0, sram_wea_o}, 32'd0);
        step(); ack_man = 1'b0; #1;
        chk("late_ack_no_write", sram_wr_cnt, wr0);
        chk("late_ack_no_ready", {31'd0, cpu_ready_o}, 32'd0);
        req(1'b0, 32'h40, '0); #1;
        chk("post_rst_0x40_miss", {31'd0, cpu_ready_o}, 32'd0);
        step(); ack_man = 1'b1; rd_man = 32'h11112222; #1;
        chk("post_rst_miss_cnt", miss_cnt_o, 32'd1);
        step(); ack_man = 1'b0; #1;
        chk("post_rst_data", cpu_rdata_o, 32'h11112222);
        step(); cpu_req_i = 1'b0;

        // zero-wait memory, 16 distinct indices
        rst_i = 1'b1; zw = 1'b1;
        step(); rst_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a = 32'h1000 + 32'(i) * 32'd4;
            step(); req(1'b0, a, '0); #1;
            if (i == 0) chk("zw_t0_ready", {31'd0, cpu_ready_o}, 32'd0);
            step(); #1;
            if (i == 0) chk("zw_t1_ready", {31'd0, cpu_ready_o}, 32'd0);
            step(); #1;
            chk($sformatf("zw_miss_ready_%0d", i), {31'd0, cpu_ready_o}, 32'd1);
            chk($sformatf("zw_miss_data_%0d", i), cpu_rdata_o, a ^ 32'hA5A5_0000);
        end
        step(); cpu_req_i = 1'b0; #1;
        chk("zw_miss_cnt", miss_cnt_o, 32'd16);
        for (int i = 0; i < 16; i++) begin
            a = 32'h1000 + 32'(i) * 32'd4;
            req(1'b0, a, '0); #1;
            chk($sformatf("zw_hit_data_%0d", i), cpu_rdata_o, a ^ 32'hA5A5_0000);
            chk($sformatf("zw_hit_ready_%0d", i), {31'd0, cpu_ready_o}, 32'd1);
            step();
        end
        cpu_req_i = 1'b0; #1;
        chk("zw_hit_cnt", hit_cnt_o, 32'd16);
        chk("zw_miss_cnt_final", miss_cnt_o, 32'd16);
        chk("zw_mem_idle", {31'd0, mem_req_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
